// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_buf
//  Description : Elastic pipeline-stage register; DEPTH-entry circular buffer
//                with valid/ready handshake, flush and occupancy count.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_buf #(
    parameter int DATA_W = 43,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
);

    localparam int                 c_ptr_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_last_ptr  = c_ptr_w'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   c_depth_cnt = CNT_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_push;
    logic w_pop;

    // Pointers wrap by comparison so non-power-of-2 depths work.
    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (r_count != c_depth_cnt);
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_count  <= '0;
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_count_bound : assert property (@(posedge clk) disable iff (!rst)
        r_count <= c_depth_cnt);
    a_bubble_zero : assert property (@(posedge clk) disable iff (!rst)
        !out_valid |-> (out_data == '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_buf
//  Description : Self-checking bench; DEPTH=2 and DEPTH=3 instances against
//                queue-based reference models with directed and random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_buf;

    localparam int DW = 43;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEPTH=2
    logic          a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [DW-1:0] a_in_data = '0;
    logic          a_in_ready, a_out_valid;
    logic [DW-1:0] a_out_data;
    logic [1:0]    a_count;

    // Instance B: DEPTH=3
    logic          b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [DW-1:0] b_in_data = '0;
    logic          b_in_ready, b_out_valid;
    logic [DW-1:0] b_out_data;
    logic [1:0]    b_count;

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(2)) u_dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count)
    );

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(3)) u_dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count)
    );

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom, $urandom});
    endfunction

    // One cycle on instance A, entered and left at a negedge.
    task automatic cyc_a(input logic fl, input logic iv, input logic [DW-1:0] d, input logic ordy);
        logic push, pop;
        a_flush = fl; a_in_valid = iv; a_in_data = d; a_out_ready = ordy;
        #1;
        check_eq("a_in_ready",  a_in_ready,  qa.size() != 2);
        check_eq("a_out_valid", a_out_valid, qa.size() != 0);
        check_eq("a_out_data",  a_out_data,  (qa.size() != 0) ? qa[0] : '0);
        check_eq("a_count",     a_count,     qa.size());
        push = iv && (qa.size() != 2);
        pop  = ordy && (qa.size() != 0);
        @(posedge clk);
        if (fl) qa.delete();
        else begin
            if (pop)  void'(qa.pop_front());
            if (push) qa.push_back(d);
        end
        #1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic cyc_b(input logic fl, input logic iv, input logic [DW-1:0] d, input logic ordy);
        logic push, pop;
        b_flush = fl; b_in_valid = iv; b_in_data = d; b_out_ready = ordy;
        #1;
        check_eq("b_in_ready",  b_in_ready,  qb.size() != 3);
        check_eq("b_out_valid", b_out_valid, qb.size() != 0);
        check_eq("b_out_data",  b_out_data,  (qb.size() != 0) ? qb[0] : '0);
        check_eq("b_count",     b_count,     qb.size());
        push = iv && (qb.size() != 3);
        pop  = ordy && (qb.size() != 0);
        @(posedge clk);
        if (fl) qb.delete();
        else begin
            if (pop)  void'(qb.pop_front());
            if (push) qb.push_back(d);
        end
        #1;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset held 3 cycles with upstream asserting valid
        a_in_valid = 1'b1; a_in_data = 43'h55;
        b_in_valid = 1'b1; b_in_data = 43'h66;
        repeat (3) @(negedge clk);
        check_eq("rst_a_count",     a_count,     0);
        check_eq("rst_a_out_valid", a_out_valid, 0);
        check_eq("rst_a_out_data",  a_out_data,  0);
        check_eq("rst_a_in_ready",  a_in_ready,  1);
        check_eq("rst_b_count",     b_count,     0);
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Streaming at full rate
        cyc_a(0, 1, 43'h11, 1);
        cyc_a(0, 1, 43'h22, 1);
        cyc_a(0, 1, 43'h33, 1);
        cyc_a(0, 0, 43'h0,  1);
        cyc_a(0, 0, 43'h0,  1);

        // Back-pressure: 0xC waits upstream until accepted
        cyc_a(0, 1, 43'hA, 0);
        cyc_a(0, 1, 43'hB, 0);
        cyc_a(0, 1, 43'hC, 0);
        cyc_a(0, 1, 43'hC, 1);
        cyc_a(0, 1, 43'hC, 1);
        cyc_a(0, 0, 43'h0, 1);
        cyc_a(0, 0, 43'h0, 1);

        // Flush with simultaneous push, full and partially full
        cyc_a(0, 1, 43'h1E1, 0);
        cyc_a(0, 1, 43'h1E2, 0);
        cyc_a(1, 1, 43'hD,   1);
        cyc_a(0, 1, 43'h2E1, 0);
        cyc_a(1, 1, 43'hD,   0);
        cyc_a(0, 0, 43'h0,   1);
        cyc_a(0, 1, 43'h3E1, 1);
        cyc_a(0, 0, 43'h0,   1);

        // Random traffic, DEPTH=2
        for (int i = 0; i < 200; i++)
            cyc_a(($urandom_range(0, 15) == 0), $urandom_range(0, 1), rnd_data(), $urandom_range(0, 1));

        // Pointer wrap, DEPTH=3
        cyc_b(0, 1, rnd_data(), 0);
        cyc_b(0, 1, rnd_data(), 0);
        for (int i = 0; i < 10; i++)
            cyc_b(0, $urandom_range(0, 1), rnd_data(), $urandom_range(0, 1));
        for (int i = 0; i < 200; i++)
            cyc_b(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), rnd_data(), $urandom_range(0, 1));

        // Async reset between edges with two entries stored
        while (qa.size() != 0) cyc_a(0, 0, 43'h0, 1);
        cyc_a(0, 1, 43'h77, 0);
        cyc_a(0, 1, 43'h88, 0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_a_out_valid", a_out_valid, 0);
        check_eq("arst_a_count",     a_count,     0);
        check_eq("arst_a_in_ready",  a_in_ready,  1);
        check_eq("arst_a_out_data",  a_out_data,  0);
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cyc_a(0, 0, 43'h0, 1);
        cyc_a(0, 1, 43'h99, 1);
        cyc_a(0, 0, 43'h0, 1);
        cyc_b(0, 0, 43'h0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
